// File: rtl/alu_pkg.sv
// Shared types and constants for the ALU arbiter controller: op codes,
// operand/result widths, FSM state encoding and divide-by-zero detection.
package alu_pkg;

  localparam int OPND_W = 3;
  localparam int SEL_W  = 2;
  localparam int RES_W  = 6;

  localparam logic [SEL_W-1:0] OP_ADD = 2'b00;
  localparam logic [SEL_W-1:0] OP_SUB = 2'b01;
  localparam logic [SEL_W-1:0] OP_MUL = 2'b10;
  localparam logic [SEL_W-1:0] OP_DIV = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    EXEC = 2'b01,
    RESP = 2'b10
  } state_t;

  function automatic logic is_div_zero(input logic [SEL_W-1:0] sel,
                                       input logic [OPND_W-1:0] b);
    return (sel == OP_DIV) && (b == {OPND_W{1'b0}});
  endfunction

endpackage

// File: rtl/alu_arbiter_ctrl_if.sv
// Bus bundle between the requesters, the consumer, the arithmetic unit and
// the controller. The controller uses the slave view.
interface alu_arbiter_ctrl_if #(
  parameter int CNT_W = 8
);
  import alu_pkg::*;

  logic              req0_valid;
  logic              req0_ready;
  logic [OPND_W-1:0] req0_a;
  logic [OPND_W-1:0] req0_b;
  logic [SEL_W-1:0]  req0_sel;

  logic              req1_valid;
  logic              req1_ready;
  logic [OPND_W-1:0] req1_a;
  logic [OPND_W-1:0] req1_b;
  logic [SEL_W-1:0]  req1_sel;

  logic [OPND_W-1:0] au_a;
  logic [OPND_W-1:0] au_b;
  logic [SEL_W-1:0]  au_sel;
  logic [RES_W-1:0]  au_result;

  logic              rsp_valid;
  logic              rsp_ready;
  logic              rsp_id;
  logic [RES_W-1:0]  rsp_result;
  logic              rsp_dz;

  logic              busy;
  logic [CNT_W-1:0]  op_count;

  modport master (
    output req0_valid, req0_a, req0_b, req0_sel,
    output req1_valid, req1_a, req1_b, req1_sel,
    output au_result, rsp_ready,
    input  req0_ready, req1_ready, au_a, au_b, au_sel,
    input  rsp_valid, rsp_id, rsp_result, rsp_dz, busy, op_count
  );

  modport slave (
    input  req0_valid, req0_a, req0_b, req0_sel,
    input  req1_valid, req1_a, req1_b, req1_sel,
    input  au_result, rsp_ready,
    output req0_ready, req1_ready, au_a, au_b, au_sel,
    output rsp_valid, rsp_id, rsp_result, rsp_dz, busy, op_count
  );

endinterface

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter: grants the lone valid requester, or the one
// that did not win last time when both are valid.
module rr_arbiter2 (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [1:0] valid,
  output logic [1:0] grant
);

  logic       last_grant_r;
  logic [1:0] grant_s;

  // Grant selection; nothing is granted while disabled.
  always_comb begin
    grant_s = 2'b00;
    if (!en) begin
      grant_s = 2'b00;
    end else if (valid == 2'b11) begin
      grant_s = last_grant_r ? 2'b01 : 2'b10;
    end else begin
      grant_s = valid;
    end
  end

  assign grant = grant_s;

  // Remember the winner of each accepted grant; reset favours requester 0 next.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant_r <= 1'b1;
    end else if (|grant_s) begin
      last_grant_r <= grant_s[1];
    end
  end

endmodule

// File: rtl/alu_arbiter_ctrl.sv
// Shares one combinational arithmetic unit between two requesters: round-robin
// accept, hold operands for EXEC_CYCLES, return the tagged result.
module alu_arbiter_ctrl
  import alu_pkg::*;
#(
  parameter int EXEC_CYCLES = 1,
  parameter int CNT_W       = 8
) (
  input logic               clk,
  input logic               rst,
  alu_arbiter_ctrl_if.slave bus
);

  localparam logic [3:0] CNT_INIT = 4'(EXEC_CYCLES - 1);

  state_t            state_r;
  state_t            state_s;
  logic [1:0]        grant_s;
  logic              arb_en_s;
  logic              accept_s;
  logic              dz_s;
  logic [OPND_W-1:0] acc_a_s;
  logic [OPND_W-1:0] acc_b_s;
  logic [SEL_W-1:0]  acc_sel_s;

  logic [3:0]        cnt_r;
  logic [OPND_W-1:0] au_a_r;
  logic [OPND_W-1:0] au_b_r;
  logic [SEL_W-1:0]  au_sel_r;
  logic              id_r;
  logic [RES_W-1:0]  rsp_result_r;
  logic              rsp_dz_r;
  logic [CNT_W-1:0]  op_count_r;

  assign arb_en_s = (state_r == IDLE) && !rst;

  rr_arbiter2 u_arb (
    .clk   (clk),
    .rst   (rst),
    .en    (arb_en_s),
    .valid ({bus.req1_valid, bus.req0_valid}),
    .grant (grant_s)
  );

  // The grant is already qualified by valid, so any grant is an accept.
  assign accept_s = |grant_s;

  // Operands of the granted requester.
  always_comb begin
    if (grant_s[1]) begin
      acc_a_s   = bus.req1_a;
      acc_b_s   = bus.req1_b;
      acc_sel_s = bus.req1_sel;
    end else begin
      acc_a_s   = bus.req0_a;
      acc_b_s   = bus.req0_b;
      acc_sel_s = bus.req0_sel;
    end
  end

  assign dz_s = is_div_zero(acc_sel_s, acc_b_s);

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          state_s = dz_s ? RESP : EXEC;
        end else begin
          state_s = IDLE;
        end
      end
      EXEC: begin
        if (cnt_r == 4'd0) begin
          state_s = RESP;
        end else begin
          state_s = EXEC;
        end
      end
      RESP: begin
        if (bus.rsp_ready) begin
          state_s = IDLE;
        end else begin
          state_s = RESP;
        end
      end
      default: state_s = IDLE;
    endcase
  end

  // Datapath: operand capture, settle counter, result capture, op counter.
  // The au_* registers double as operand capture and are non-zero only in EXEC.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r        <= 4'd0;
      au_a_r       <= {OPND_W{1'b0}};
      au_b_r       <= {OPND_W{1'b0}};
      au_sel_r     <= {SEL_W{1'b0}};
      id_r         <= 1'b0;
      rsp_result_r <= {RES_W{1'b0}};
      rsp_dz_r     <= 1'b0;
      op_count_r   <= {CNT_W{1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            id_r <= grant_s[1];
            if (dz_s) begin
              rsp_result_r <= {RES_W{1'b0}};
              rsp_dz_r     <= 1'b1;
            end else begin
              au_a_r   <= acc_a_s;
              au_b_r   <= acc_b_s;
              au_sel_r <= acc_sel_s;
              cnt_r    <= CNT_INIT;
            end
          end
        end
        EXEC: begin
          if (cnt_r == 4'd0) begin
            rsp_result_r <= bus.au_result;
            rsp_dz_r     <= 1'b0;
            au_a_r       <= {OPND_W{1'b0}};
            au_b_r       <= {OPND_W{1'b0}};
            au_sel_r     <= {SEL_W{1'b0}};
          end else begin
            cnt_r <= cnt_r - 4'd1;
          end
        end
        RESP: begin
          if (bus.rsp_ready) begin
            op_count_r <= op_count_r + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.req0_ready = grant_s[0];
  assign bus.req1_ready = grant_s[1];
  assign bus.au_a       = au_a_r;
  assign bus.au_b       = au_b_r;
  assign bus.au_sel     = au_sel_r;
  assign bus.rsp_valid  = (state_r == RESP);
  assign bus.rsp_id     = id_r;
  assign bus.rsp_result = rsp_result_r;
  assign bus.rsp_dz     = rsp_dz_r;
  assign bus.busy       = (state_r != IDLE);
  assign bus.op_count   = op_count_r;

endmodule

// File: tb/tb_alu_arbiter_ctrl.sv
// Self-checking bench for alu_arbiter_ctrl: vector table, corner-case sequences
// and randomized traffic against a cycle-level behavioural model.
module tb_alu_arbiter_ctrl;
  import alu_pkg::*;

  logic clk = 1'b0;
  logic rst0;
  logic rst1;
  int   total = 0;
  int   bad = 0;
  int   ops0 = 0;

  always #5 clk = ~clk;

  alu_arbiter_ctrl_if #(.CNT_W(8)) bus0 ();
  alu_arbiter_ctrl_if #(.CNT_W(2)) bus1 ();

  alu_arbiter_ctrl #(.EXEC_CYCLES(1), .CNT_W(8)) u_dut0 (.clk(clk), .rst(rst0), .bus(bus0));
  alu_arbiter_ctrl #(.EXEC_CYCLES(4), .CNT_W(2)) u_dut1 (.clk(clk), .rst(rst1), .bus(bus1));

  // Stand-in for the external arithmetic unit.
  function automatic logic [5:0] au_model(input logic [2:0] a, input logic [2:0] b,
                                          input logic [1:0] sel);
    int r;
    case (sel)
      2'b00:   r = int'(a) + int'(b);
      2'b01:   r = int'(a) - int'(b);
      2'b10:   r = int'(a) * int'(b);
      default: r = (b == 3'd0) ? 0 : int'(a) / int'(b);
    endcase
    return r[5:0];
  endfunction

  assign bus0.au_result = au_model(bus0.au_a, bus0.au_b, bus0.au_sel);
  assign bus1.au_result = au_model(bus1.au_a, bus1.au_b, bus1.au_sel);

  typedef struct {
    bit         id;
    logic [2:0] a;
    logic [2:0] b;
    logic [1:0] sel;
    logic [5:0] res;
    bit         dz;
  } vec_t;

  vec_t vecs[9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input bit id, input logic v, input logic [2:0] a,
                         input logic [2:0] b, input logic [1:0] sel);
    if (id) begin
      bus0.req1_valid = v; bus0.req1_a = a; bus0.req1_b = b; bus0.req1_sel = sel;
    end else begin
      bus0.req0_valid = v; bus0.req0_a = a; bus0.req0_b = b; bus0.req0_sel = sel;
    end
  endtask

  task automatic run_vec(input vec_t v);
    int lat;
    set_req(v.id, 1'b1, v.a, v.b, v.sel);
    #1;
    check("vec_ready", {bus0.req1_ready, bus0.req0_ready}, v.id ? 2 : 1);
    tick();
    set_req(v.id, 1'b0, 3'($urandom), 3'($urandom), 2'($urandom));
    lat = 1;
    if (v.dz) check("dz_au_zero", {bus0.au_a, bus0.au_b, bus0.au_sel}, 0);
    else      check("exec_au", {bus0.au_a, bus0.au_b, bus0.au_sel}, {v.a, v.b, v.sel});
    while (!bus0.rsp_valid && lat < 20) begin
      tick();
      lat++;
    end
    check("vec_latency", lat, v.dz ? 1 : 2);
    check("vec_rsp", {bus0.rsp_id, bus0.rsp_dz, bus0.rsp_result}, {v.id, v.dz, v.res});
    tick();
    ops0++;
    check("vec_idle", {bus0.rsp_valid, bus0.busy}, 0);
    check("vec_count", bus0.op_count, ops0);
  endtask

  task automatic reset0();
    rst0 = 1'b1;
    tick();
    rst0 = 1'b0;
    ops0 = 0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{1'b0, 3'd3, 3'd2, OP_ADD, 6'd5,  1'b0};
    vecs[1] = '{1'b1, 3'd5, 3'd6, OP_ADD, 6'd11, 1'b0};
    vecs[2] = '{1'b0, 3'd7, 3'd7, OP_MUL, 6'd49, 1'b0};
    vecs[3] = '{1'b1, 3'd2, 3'd5, OP_SUB, 6'd61, 1'b0};
    vecs[4] = '{1'b0, 3'd6, 3'd3, OP_DIV, 6'd2,  1'b0};
    vecs[5] = '{1'b1, 3'd6, 3'd0, OP_DIV, 6'd0,  1'b1};
    vecs[6] = '{1'b0, 3'd0, 3'd0, OP_DIV, 6'd0,  1'b1};
    vecs[7] = '{1'b1, 3'd7, 3'd2, OP_DIV, 6'd3,  1'b0};
    vecs[8] = '{1'b0, 3'd4, 3'd4, OP_SUB, 6'd0,  1'b0};

    bus0.req0_valid = 1'b0; bus0.req0_a = 3'd0; bus0.req0_b = 3'd0; bus0.req0_sel = 2'd0;
    bus0.req1_valid = 1'b0; bus0.req1_a = 3'd0; bus0.req1_b = 3'd0; bus0.req1_sel = 2'd0;
    bus0.rsp_ready  = 1'b1;
    bus1.req0_valid = 1'b0; bus1.req0_a = 3'd0; bus1.req0_b = 3'd0; bus1.req0_sel = 2'd0;
    bus1.req1_valid = 1'b0; bus1.req1_a = 3'd0; bus1.req1_b = 3'd0; bus1.req1_sel = 2'd0;
    bus1.rsp_ready  = 1'b1;
    rst0 = 1'b1;
    rst1 = 1'b1;
    tick();
    tick();
    check("reset_outputs0", {bus0.req0_ready, bus0.req1_ready, bus0.au_a, bus0.au_b, bus0.au_sel,
          bus0.rsp_valid, bus0.rsp_id, bus0.rsp_result, bus0.rsp_dz, bus0.busy, bus0.op_count}, 0);
    check("reset_outputs1", {bus1.req0_ready, bus1.req1_ready, bus1.au_a, bus1.au_b, bus1.au_sel,
          bus1.rsp_valid, bus1.rsp_id, bus1.rsp_result, bus1.rsp_dz, bus1.busy, bus1.op_count}, 0);
    rst0 = 1'b0;
    rst1 = 1'b0;

    for (int i = 0; i < 9; i++) run_vec(vecs[i]);

    // Back-pressure: response held while the consumer stalls.
    bus0.rsp_ready = 1'b0;
    set_req(1'b0, 1'b1, 3'd5, 3'd3, OP_SUB);
    #1;
    tick();
    set_req(1'b0, 1'b0, 3'd0, 3'd0, OP_ADD);
    for (int k = 0; k < 20 && !bus0.rsp_valid; k++) tick();
    set_req(1'b0, 1'b1, 3'd1, 3'd1, OP_ADD);
    set_req(1'b1, 1'b1, 3'd2, 3'd2, OP_ADD);
    for (int k = 0; k < 5; k++) begin
      #1;
      check("bp_rsp_hold", {bus0.rsp_valid, bus0.rsp_id, bus0.rsp_dz, bus0.rsp_result},
            {1'b1, 1'b0, 1'b0, 6'd2});
      check("bp_ready_busy", {bus0.req1_ready, bus0.req0_ready, bus0.busy}, 3'b001);
      tick();
    end
    set_req(1'b0, 1'b0, 3'd0, 3'd0, OP_ADD);
    set_req(1'b1, 1'b0, 3'd0, 3'd0, OP_ADD);
    bus0.rsp_ready = 1'b1;
    tick();
    ops0++;
    check("bp_release", {bus0.rsp_valid, bus0.busy}, 0);
    check("bp_count", bus0.op_count, ops0);

    // Continuous contention after reset: grants must alternate starting at 0.
    begin
      int grants[$];
      reset0();
      set_req(1'b0, 1'b1, 3'd1, 3'd1, OP_ADD);
      set_req(1'b1, 1'b1, 3'd2, 3'd3, OP_MUL);
      for (int c = 0; c < 40 && grants.size() < 4; c++) begin
        #1;
        check("contention_onehot", bus0.req0_ready & bus0.req1_ready, 0);
        if (bus0.req0_ready) grants.push_back(0);
        else if (bus0.req1_ready) grants.push_back(1);
        tick();
      end
      set_req(1'b0, 1'b0, 3'd0, 3'd0, OP_ADD);
      set_req(1'b1, 1'b0, 3'd0, 3'd0, OP_ADD);
      check("contention_grants", grants.size(), 4);
      for (int i = 0; i < grants.size(); i++) check("contention_order", grants[i], i % 2);
      for (int k = 0; k < 10 && bus0.busy; k++) tick();
      check("contention_count", bus0.op_count, 4);
    end

    // Randomized traffic against a cycle-level model of the arbitration rules.
    begin
      bit         free = 1'b1;
      bit         last = 1'b1;
      bit         pend = 1'b0;
      bit         pend_id = 1'b0;
      bit         pend_dz = 1'b0;
      logic [5:0] pend_res = 6'd0;
      int         due = 0;
      int         count = 0;
      reset0();
      for (int c = 0; c < 400; c++) begin
        logic       v0, v1, exp_valid, id, dz;
        logic [1:0] exp_g;
        logic [2:0] a0, b0, a1, b1;
        logic [1:0] s0, s1;
        v0 = 1'($urandom); v1 = 1'($urandom);
        a0 = 3'($urandom); b0 = 3'($urandom); s0 = 2'($urandom);
        a1 = 3'($urandom); b1 = 3'($urandom); s1 = 2'($urandom);
        set_req(1'b0, v0, a0, b0, s0);
        set_req(1'b1, v1, a1, b1, s1);
        bus0.rsp_ready = ($urandom_range(0, 3) != 0);
        #1;
        exp_g = 2'b00;
        if (free) exp_g = (v0 && v1) ? (last ? 2'b01 : 2'b10) : {v1, v0};
        check("rand_ready", {bus0.req1_ready, bus0.req0_ready}, exp_g);
        exp_valid = pend && (c >= due);
        check("rand_valid", bus0.rsp_valid, exp_valid);
        check("rand_busy", bus0.busy, !free);
        check("rand_count", bus0.op_count, count % 256);
        if (exp_valid)
          check("rand_rsp", {bus0.rsp_id, bus0.rsp_dz, bus0.rsp_result}, {pend_id, pend_dz, pend_res});
        if (exp_valid && bus0.rsp_ready) begin
          pend = 1'b0;
          free = 1'b1;
          count++;
        end
        if (exp_g != 2'b00) begin
          id       = exp_g[1];
          dz       = id ? (s1 == 2'b11 && b1 == 3'd0) : (s0 == 2'b11 && b0 == 3'd0);
          pend     = 1'b1;
          pend_id  = id;
          pend_dz  = dz;
          pend_res = dz ? 6'd0 : (id ? au_model(a1, b1, s1) : au_model(a0, b0, s0));
          due      = c + (dz ? 1 : 2);
          free     = 1'b0;
          last     = id;
        end
        tick();
      end
      set_req(1'b0, 1'b0, 3'd0, 3'd0, OP_ADD);
      set_req(1'b1, 1'b0, 3'd0, 3'd0, OP_ADD);
      bus0.rsp_ready = 1'b1;
    end

    // Reset in the second EXEC cycle (EXEC_CYCLES=4) aborts the operation.
    bus1.req0_valid = 1'b1; bus1.req0_a = 3'd3; bus1.req0_b = 3'd2; bus1.req0_sel = OP_ADD;
    #1;
    check("abort_accept", {bus1.req1_ready, bus1.req0_ready}, 2'b01);
    tick();
    bus1.req0_valid = 1'b0;
    check("abort_exec_au", {bus1.au_a, bus1.au_b, bus1.au_sel, bus1.busy}, {3'd3, 3'd2, OP_ADD, 1'b1});
    tick();
    rst1 = 1'b1;
    tick();
    check("abort_outputs", {bus1.req0_ready, bus1.req1_ready, bus1.au_a, bus1.au_b, bus1.au_sel,
          bus1.rsp_valid, bus1.rsp_id, bus1.rsp_result, bus1.rsp_dz, bus1.busy, bus1.op_count}, 0);
    rst1 = 1'b0;
    for (int k = 0; k < 8; k++) begin
      tick();
      check("abort_no_rsp", {bus1.rsp_valid, bus1.busy, bus1.op_count}, 0);
    end
    bus1.req0_valid = 1'b1;
    bus1.req1_valid = 1'b1;
    #1;
    check("abort_regrant0", {bus1.req1_ready, bus1.req0_ready}, 2'b01);
    #1;
    bus1.req0_valid = 1'b0;
    bus1.req1_valid = 1'b0;
    tick();
    check("dropped_valid", bus1.busy, 0);

    // Counter wrap with a 2-bit op counter, also checking 5-cycle latency.
    for (int k = 0; k < 5; k++) begin
      int lat;
      bit id;
      id = k[0];
      if (id) begin
        bus1.req1_valid = 1'b1; bus1.req1_a = 3'(k + 1); bus1.req1_b = 3'd1; bus1.req1_sel = OP_ADD;
      end else begin
        bus1.req0_valid = 1'b1; bus1.req0_a = 3'(k + 1); bus1.req0_b = 3'd1; bus1.req0_sel = OP_ADD;
      end
      #1;
      tick();
      bus1.req0_valid = 1'b0;
      bus1.req1_valid = 1'b0;
      lat = 1;
      while (!bus1.rsp_valid && lat < 30) begin
        tick();
        lat++;
      end
      check("wrap_latency", lat, 5);
      check("wrap_rsp", {bus1.rsp_id, bus1.rsp_dz, bus1.rsp_result}, {id, 1'b0, 6'(k + 2)});
      tick();
      check("wrap_count", bus1.op_count, (k + 1) % 4);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
